// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one registered BUS_SIZE-bit adder among CHANNELS requesters
//
// Ports:
//   i_clk      clock, rising edge
//   i_reset_n  synchronous active-low reset
//   i_req      per-channel request level
//   i_op_a     flattened operand A, channel i at [i*BUS_SIZE +: BUS_SIZE]
//   i_op_b     flattened operand B, same layout
//   o_gnt      one-hot grant, high from capture through the done cycle
//   o_done     one-hot single-cycle completion pulse, qualifies o_result
//   o_result   registered sum of the granted channel's operands
//   o_busy     high whenever the FSM is not idle
//   o_carry    carry out of the sum (only with ADDER_ARBITER_CARRY_EN defined)
//
// Optional feature macro: ADDER_ARBITER_CARRY_EN
module adder_arbiter #(
    parameter int BUS_SIZE = 32,
    parameter int CHANNELS = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [CHANNELS-1:0]          i_req,
    input  logic [CHANNELS*BUS_SIZE-1:0] i_op_a,
    input  logic [CHANNELS*BUS_SIZE-1:0] i_op_b,
    output logic [CHANNELS-1:0]          o_gnt,
    output logic [CHANNELS-1:0]          o_done,
    output logic [BUS_SIZE-1:0]          o_result,
`ifdef ADDER_ARBITER_CARRY_EN
    output logic                         o_busy,
    output logic                         o_carry
`else
    output logic                         o_busy
`endif
);
    localparam int IDX_W = $clog2(CHANNELS);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    idx;
    logic [BUS_SIZE-1:0] a_reg;
    logic [BUS_SIZE-1:0] b_reg;
    logic                sel_valid;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    ptr_next;
    int                  c;

    // Scan from the farthest offset back to ptr so the channel closest to ptr wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx = '0;
        c = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % CHANNELS;
            if (i_req[c]) begin
                sel_valid = 1'b1;
                sel_idx = IDX_W'(c);
            end
        end
    end

    // The channel just served moves to the lowest priority.
    assign ptr_next = (idx == IDX_W'(CHANNELS - 1)) ? '0 : idx + 1'b1;
    assign o_busy = state != IDLE;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= IDLE;
            ptr <= '0;
            idx <= '0;
            a_reg <= '0;
            b_reg <= '0;
            o_gnt <= '0;
            o_done <= '0;
            o_result <= '0;
`ifdef ADDER_ARBITER_CARRY_EN
            o_carry <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (sel_valid) begin
                    idx <= sel_idx;
                    a_reg <= i_op_a[int'(sel_idx)*BUS_SIZE +: BUS_SIZE];
                    b_reg <= i_op_b[int'(sel_idx)*BUS_SIZE +: BUS_SIZE];
                    o_gnt <= CHANNELS'(1) << sel_idx;
                    state <= EXEC;
                end
                EXEC: begin
`ifdef ADDER_ARBITER_CARRY_EN
                    {o_carry, o_result} <= {1'b0, a_reg} + {1'b0, b_reg};
`else
                    o_result <= a_reg + b_reg;
`endif
                    o_done <= o_gnt;
                    state <= DONE;
                end
                DONE: begin
                    ptr <= ptr_next;
                    o_gnt <= '0;
                    o_done <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed self-checking bench for adder_arbiter
module tb_adder_arbiter;
    localparam int BUS = 32;
    localparam int CH = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [CH-1:0]     req = '0;
    logic [CH*BUS-1:0] op_a = '0;
    logic [CH*BUS-1:0] op_b = '0;
    logic [CH-1:0]     gnt;
    logic [CH-1:0]     done;
    logic [BUS-1:0]    result;
    logic              busy;
`ifdef ADDER_ARBITER_CARRY_EN
    logic              carry;
`endif
    int vectors = 0;
    int miscompares = 0;

    adder_arbiter #(.BUS_SIZE(BUS), .CHANNELS(CH)) dut (
        .i_clk(clk),
        .i_reset_n(reset_n),
        .i_req(req),
        .i_op_a(op_a),
        .i_op_b(op_b),
        .o_gnt(gnt),
        .o_done(done),
        .o_result(result),
`ifdef ADDER_ARBITER_CARRY_EN
        .o_busy(busy),
        .o_carry(carry)
`else
        .o_busy(busy)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int ch, input logic [BUS-1:0] a, input logic [BUS-1:0] b);
        op_a[ch*BUS +: BUS] = a;
        op_b[ch*BUS +: BUS] = b;
    endtask

    // Grant cycle, done cycle, idle cycle for one transaction on channel ch.
    task automatic txn(input string tag, input int ch, input logic [BUS-1:0] sum, input logic drop);
        step();
        chk({tag, "_gnt"}, gnt, 64'(CH'(1) << ch));
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_nodone"}, done, 0);
        if (drop) req = '0;
        step();
        chk({tag, "_done"}, done, 64'(CH'(1) << ch));
        chk({tag, "_gnt_hold"}, gnt, 64'(CH'(1) << ch));
        chk({tag, "_result"}, result, sum);
        step();
        chk({tag, "_idle_gnt"}, gnt, 0);
        chk({tag, "_idle_done"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        step();
        chk("idle_noreq", gnt, 0);

        set_op(1, 32'd5, 32'd7);
        req = 4'b0010;
        txn("single", 1, 32'd12, 1'b1);
        chk("single_hold", result, 32'd12);

        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < CH; i++) set_op(i, 32'(10 * (i + 1)), 32'(i + 1));
        req = 4'b1111;
        txn("rr0", 0, 32'd11, 1'b0);
        txn("rr1", 1, 32'd22, 1'b0);
        txn("rr2", 2, 32'd33, 1'b0);
        txn("rr3", 3, 32'd44, 1'b0);
        txn("rr4", 0, 32'd11, 1'b1);

        set_op(2, 32'd100, 32'd1);
        req = 4'b0100;
        step();
        chk("cap_gnt", gnt, 4'b0100);
        req = '0;
        set_op(2, 32'd0, 32'd0);
        step();
        chk("cap_done", done, 4'b0100);
        chk("cap_result", result, 32'd101);
        step();

        set_op(3, 32'hFFFF_FFFF, 32'd2);
        req = 4'b1000;
        step();
        chk("ovf_gnt", gnt, 4'b1000);
        req = '0;
        step();
        chk("ovf_result", result, 32'd1);
`ifdef ADDER_ARBITER_CARRY_EN
        chk("ovf_carry", carry, 1);
`endif
        step();
        set_op(0, 32'd1, 32'd1);
        req = 4'b1001;
        step();
        chk("wrap_gnt", gnt, 4'b0001);
        req = '0;
        step();
        chk("small_result", result, 32'd2);
`ifdef ADDER_ARBITER_CARRY_EN
        chk("small_carry", carry, 0);
`endif
        step();

        req = 4'b0001;
        step();
        chk("mid_gnt", gnt, 4'b0001);
        req = '0;
        reset_n = 1'b0;
        step();
        chk("mid_gnt0", gnt, 0);
        chk("mid_done0", done, 0);
        chk("mid_result0", result, 0);
        chk("mid_busy0", busy, 0);
        reset_n = 1'b1;
        step();
        chk("mid_nodone", done, 0);
        set_op(3, 32'd3, 32'd4);
        req = 4'b1000;
        txn("post_rst", 3, 32'd7, 1'b1);

        set_op(0, 32'd20, 32'd1);
        set_op(2, 32'd30, 32'd2);
        req = 4'b0101;
        step();
        chk("drop_gnt0", gnt, 4'b0001);
        req = 4'b0100;
        step();
        chk("drop_done0", done, 4'b0001);
        chk("drop_result0", result, 32'd21);
        step();
        txn("drop_ch2", 2, 32'd32, 1'b1);

        set_op(3, 32'd8, 32'd9);
        req = 4'b1001;
        txn("ptr3", 3, 32'd17, 1'b0);
        txn("ptr0", 0, 32'd21, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
